// File: rtl/mod_n_counter_if.sv
// Command and status bundle for one mod_n_counter stage; WIDTH must match the attached counter.
// TENS/UNITS exist only when MODCNT_BCD_EN is defined.
interface mod_n_counter_if #(
    parameter int WIDTH = 5
);
    logic             Enable;
    logic             LD;
    logic             Up;
    logic             Down;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] COUNT;
    logic             TC;
    logic             WRAP;
    logic             LD_ERR;
`ifdef MODCNT_BCD_EN
    logic [3:0]       TENS;
    logic [3:0]       UNITS;

    modport master (
        output Enable, LD, Up, Down, D,
        input  COUNT, TC, WRAP, LD_ERR, TENS, UNITS
    );
    modport slave (
        input  Enable, LD, Up, Down, D,
        output COUNT, TC, WRAP, LD_ERR, TENS, UNITS
    );
`else
    modport master (
        output Enable, LD, Up, Down, D,
        input  COUNT, TC, WRAP, LD_ERR
    );
    modport slave (
        input  Enable, LD, Up, Down, D,
        output COUNT, TC, WRAP, LD_ERR
    );
`endif
endinterface

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with checked load, cascade TC and optional BCD digits (MODCNT_BCD_EN).
// Latency: COUNT/WRAP/LD_ERR/BCD one cycle after a qualified command; TC combinational.
// Backpressure: none; Enable qualifies every command and doubles as the cascade carry-in.
module mod_n_counter #(
    parameter int MODULUS   = 24,
    parameter int WIDTH     = 5,
    parameter int RESET_VAL = 0
) (
    input logic            Clk,
    input logic            Clr,
    mod_n_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH) || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_params
            $error("mod_n_counter: illegal MODULUS/WIDTH/RESET_VAL combination");
        end
    endgenerate

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_q;
    logic             wrap_nxt;
    logic             ld_err_q;
    logic             ld_err_nxt;
    logic             at_max;
    logic             at_zero;
    logic             d_in_range;

    assign at_max     = (count_q == MAX_VAL);
    assign at_zero    = (count_q == '0);
    // Compare one bit wider so MODULUS == 2^WIDTH is representable.
    assign d_in_range = ({1'b0, bus.D} < MOD_EXT);

    always_comb begin
        count_nxt  = count_q;
        wrap_nxt   = 1'b0;
        ld_err_nxt = 1'b0;
        if (bus.Enable && bus.LD) begin
            if (d_in_range) begin
                count_nxt = bus.D;
            end else begin
                count_nxt  = '0;
                ld_err_nxt = 1'b1;
            end
        end else if (bus.Enable && (bus.Up ^ bus.Down)) begin
            if (bus.Up) begin
                if (at_max) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    count_nxt = MAX_VAL;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            count_q  <= RST_VAL;
            wrap_q   <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            count_q  <= count_nxt;
            wrap_q   <= wrap_nxt;
            ld_err_q <= ld_err_nxt;
        end
    end

    // Carry-out is purely combinational so the next stage advances on the same edge.
    assign bus.TC     = bus.Enable & ~bus.LD &
                        ((bus.Up & ~bus.Down & at_max) | (bus.Down & ~bus.Up & at_zero));
    assign bus.COUNT  = count_q;
    assign bus.WRAP   = wrap_q;
    assign bus.LD_ERR = ld_err_q;

`ifdef MODCNT_BCD_EN
    generate
        if (MODULUS > 100) begin : g_bad_bcd
            $error("mod_n_counter: MODCNT_BCD_EN needs MODULUS <= 100");
        end
    endgenerate

    localparam logic [3:0] RST_TENS  = 4'(RESET_VAL / 10);
    localparam logic [3:0] RST_UNITS = 4'(RESET_VAL % 10);

    logic [7:0] bin8;
    logic [3:0] tens_nxt;
    logic [3:0] units_nxt;
    logic [3:0] tens_q;
    logic [3:0] units_q;

    // Digits come from the next-state value so they line up with COUNT.
    always_comb begin
        bin8      = 8'(count_nxt);
        tens_nxt  = 4'(bin8 / 8'd10);
        units_nxt = 4'(bin8 % 8'd10);
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            tens_q  <= RST_TENS;
            units_q <= RST_UNITS;
        end else begin
            tens_q  <= tens_nxt;
            units_q <= units_nxt;
        end
    end

    assign bus.TENS  = tens_q;
    assign bus.UNITS = units_q;
`endif
endmodule
